// File: rtl/uart_rx_if.sv
// Serial input line and received-byte outputs of the UART receiver.
interface uart_rx_if;
    logic       RX;
    logic [7:0] RX_data;
    logic       RX_valid;
    logic       RX_frame_err;
    logic       q_busy;

    // Receiver side: samples the line, produces the byte strobes
    modport master (
        input  RX,
        output RX_data,
        output RX_valid,
        output RX_frame_err,
        output q_busy
    );

    // Line driver / command decoder side
    modport slave (
        output RX,
        input  RX_data,
        input  RX_valid,
        input  RX_frame_err,
        input  q_busy
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle valid / framing-error strobes.
module uart_rx #(
    parameter int unsigned BAUDRATE = 300000,
    parameter int unsigned CLK_FREQ = 50000000
) (
    input  logic       clk,
    input  logic       reset,
    uart_rx_if.master  rx_if
);
    localparam int unsigned CYCLES = CLK_FREQ / BAUDRATE;
    localparam int unsigned HALF   = CYCLES / 2;
    localparam int unsigned CNT_W  = $clog2(CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        WAIT_HIGH
    } state_e;

    state_e             state_q, state_d;
    logic [1:0]         sync_q, sync_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         bit_q, bit_d;
    logic [7:0]         shift_q, shift_d;
    logic [7:0]         data_q, data_d;
    logic               valid_q, valid_d;
    logic               ferr_q, ferr_d;
    logic               rx_s;

    assign rx_s = sync_q[1];

    // Two-stage synchronizer input for the asynchronous line
    always_comb begin
        sync_d = {sync_q[0], rx_if.RX};
    end

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
        end
    end

    // Next-state, bit-period counter and sampling decisions
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CNT_W'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                if (cnt_q == CNT_W'(HALF - 1)) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = DATA;
                        bit_d   = 3'd0;
                    end else begin
                        // Start bit did not survive to mid-bit: treat as a glitch
                        state_d = IDLE;
                    end
                end
            end
            DATA: begin
                if (cnt_q == CNT_W'(CYCLES - 1)) begin
                    cnt_d   = '0;
                    shift_d = {rx_s, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt_q == CNT_W'(CYCLES - 1)) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        data_d  = shift_q;
                        valid_d = 1'b1;
                        state_d = IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                // A held-low line must return high before another start is accepted
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_if.RX_data      = data_q;
    assign rx_if.RX_valid     = valid_q;
    assign rx_if.RX_frame_err = ferr_q;
    assign rx_if.q_busy       = (state_q != IDLE);

endmodule
